// File: rtl/arm7_register_file.sv
// ARMv4 architectural register file: R0-R15 with mode banking, CPSR and five SPSRs.
// Reads are registered; banking always follows the CPSR held before the edge.
module arm7_register_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_en,
  input  logic [3:0]  write_reg,
  input  logic [31:0] write_value,
  input  logic        write_restore_from_SPSR,
  input  logic        read_en,
  input  logic [3:0]  read_reg,
  output logic [31:0] read_value,
  input  logic        cpsr_read_en,
  output logic [31:0] cpsr_read_value,
  input  logic        cpsr_write_en,
  input  logic [31:0] cpsr_write_value,
  input  logic        mode_read_en,
  output logic [31:0] mode_read_value
);

  typedef enum logic [2:0] {
    BK_USR = 3'd0,
    BK_FIQ = 3'd1,
    BK_IRQ = 3'd2,
    BK_SVC = 3'd3,
    BK_ABT = 3'd4,
    BK_UND = 3'd5
  } bank_e;

  localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

  // SYS and every unrecognised encoding fall back to the user bank (no SPSR).
  function automatic bank_e bank_of(input logic [4:0] m);
    case (m)
      5'b10001: bank_of = BK_FIQ;
      5'b10010: bank_of = BK_IRQ;
      5'b10011: bank_of = BK_SVC;
      5'b10111: bank_of = BK_ABT;
      5'b11011: bank_of = BK_UND;
      default:  bank_of = BK_USR;
    endcase
  endfunction

  // Physical layout: 0-7 R0-R7, 8-12 R8-R12 (non-FIQ), 13-14 R13/R14 (USR/SYS),
  // 15 PC, 16-20 FIQ R8-R12, then R13/R14 pairs for FIQ, IRQ, SVC, ABT, UND.
  function automatic logic [4:0] phys_idx(input logic [3:0] r, input bank_e b);
    logic [4:0] base;
    if (r <= 4'd7 || r == 4'd15) begin
      phys_idx = {1'b0, r};
    end else if (r <= 4'd12) begin
      phys_idx = (b == BK_FIQ) ? (5'd16 + {1'b0, r - 4'd8}) : {1'b0, r};
    end else begin
      case (b)
        BK_FIQ:  base = 5'd21;
        BK_IRQ:  base = 5'd23;
        BK_SVC:  base = 5'd25;
        BK_ABT:  base = 5'd27;
        BK_UND:  base = 5'd29;
        default: base = 5'd13;
      endcase
      phys_idx = base + {4'b0, ~r[0]};
    end
  endfunction

  logic [31:0] regs_q [0:30];
  logic [31:0] spsr_q [0:5];
  logic [31:0] cpsr_q, cpsr_d;
  logic [31:0] read_value_q, cpsr_read_value_q, mode_read_value_q;

  bank_e      cur_bank, new_bank;
  logic       restore, spsr_save;
  logic [4:0] wr_idx, rd_idx;

  always_comb begin
    cur_bank  = bank_of(cpsr_q[4:0]);
    new_bank  = bank_of(cpsr_write_value[4:0]);
    wr_idx    = phys_idx(write_reg, cur_bank);
    rd_idx    = phys_idx(read_reg, cur_bank);
    restore   = write_en && (write_reg == 4'd15) && write_restore_from_SPSR &&
                (cur_bank != BK_USR);
    // A restore on the same edge overrides the explicit CPSR write entirely.
    spsr_save = cpsr_write_en && !restore && (new_bank != BK_USR) &&
                (cpsr_write_value[4:0] != cpsr_q[4:0]);
    cpsr_d    = cpsr_q;
    if (restore) begin
      cpsr_d = spsr_q[cur_bank];
    end else if (cpsr_write_en) begin
      cpsr_d = cpsr_write_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 31; i++) regs_q[i] <= '0;
      for (int i = 0; i < 6; i++) spsr_q[i] <= '0;
      cpsr_q            <= CPSR_RESET;
      read_value_q      <= '0;
      cpsr_read_value_q <= '0;
      mode_read_value_q <= '0;
    end else begin
      if (write_en) regs_q[wr_idx] <= write_value;
      if (spsr_save) spsr_q[new_bank] <= cpsr_q;
      cpsr_q <= cpsr_d;
      if (read_en) read_value_q <= regs_q[rd_idx];
      if (cpsr_read_en) cpsr_read_value_q <= cpsr_q;
      if (mode_read_en) mode_read_value_q <= {27'b0, cpsr_q[4:0]};
    end
  end

  assign read_value      = read_value_q;
  assign cpsr_read_value = cpsr_read_value_q;
  assign mode_read_value = mode_read_value_q;

endmodule

// File: tb/tb_arm7_register_file.sv
// Bench for arm7_register_file: directed scenarios then random traffic, checked
// through per-port expectation queues against a mode-view reference model.
module tb_arm7_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_en, write_restore_from_SPSR, read_en, cpsr_read_en;
  logic        cpsr_write_en, mode_read_en;
  logic [3:0]  write_reg, read_reg;
  logic [31:0] write_value, cpsr_write_value;
  logic [31:0] read_value, cpsr_read_value, mode_read_value;

  always #5 clk = ~clk;

  arm7_register_file dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .write_en                (write_en),
    .write_reg               (write_reg),
    .write_value             (write_value),
    .write_restore_from_SPSR (write_restore_from_SPSR),
    .read_en                 (read_en),
    .read_reg                (read_reg),
    .read_value              (read_value),
    .cpsr_read_en            (cpsr_read_en),
    .cpsr_read_value         (cpsr_read_value),
    .cpsr_write_en           (cpsr_write_en),
    .cpsr_write_value        (cpsr_write_value),
    .mode_read_en            (mode_read_en),
    .mode_read_value         (mode_read_value)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: what each mode sees, organised by the banking rules.
  logic [31:0] m_lo     [0:7];
  logic [31:0] m_pc;
  logic [31:0] m_hi_usr [8:12];
  logic [31:0] m_hi_fiq [8:12];
  logic [31:0] m_sp     [0:5];
  logic [31:0] m_lr     [0:5];
  logic [31:0] m_spsr   [0:5];
  logic [31:0] m_cpsr;

  function automatic int mbank(input logic [4:0] m);
    case (m)
      5'h11:   return 1;
      5'h12:   return 2;
      5'h13:   return 3;
      5'h17:   return 4;
      5'h1B:   return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input int r);
    int b;
    b = mbank(m_cpsr[4:0]);
    if (r < 8)   return m_lo[r];
    if (r == 15) return m_pc;
    if (r <= 12) return (b == 1) ? m_hi_fiq[r] : m_hi_usr[r];
    if (r == 13) return m_sp[b];
    return m_lr[b];
  endfunction

  task automatic mwrite(input int r, input logic [31:0] v);
    int b;
    b = mbank(m_cpsr[4:0]);
    if (r < 8)         m_lo[r] = v;
    else if (r == 15)  m_pc = v;
    else if (r <= 12) begin
      if (b == 1) m_hi_fiq[r] = v; else m_hi_usr[r] = v;
    end
    else if (r == 13)  m_sp[b] = v;
    else               m_lr[b] = v;
  endtask

  task automatic mreset();
    for (int i = 0; i < 8; i++) m_lo[i] = '0;
    for (int i = 8; i <= 12; i++) begin m_hi_usr[i] = '0; m_hi_fiq[i] = '0; end
    for (int i = 0; i < 6; i++) begin m_sp[i] = '0; m_lr[i] = '0; m_spsr[i] = '0; end
    m_pc   = '0;
    m_cpsr = 32'h0000_00D3;
  endtask

  logic [31:0] q_rd[$];
  logic [31:0] q_cp[$];
  logic [31:0] q_md[$];

  task automatic step(input bit we, input logic [3:0] wr, input logic [31:0] wv, input bit rs,
                      input bit re, input logic [3:0] rr, input bit cre,
                      input bit cwe, input logic [31:0] cwv, input bit mre);
    int b, nb;
    logic [31:0] old;
    @(negedge clk);
    write_en = we; write_reg = wr; write_value = wv; write_restore_from_SPSR = rs;
    read_en = re; read_reg = rr; cpsr_read_en = cre;
    cpsr_write_en = cwe; cpsr_write_value = cwv; mode_read_en = mre;
    if (re)  q_rd.push_back(mread(int'(rr)));
    if (cre) q_cp.push_back(m_cpsr);
    if (mre) q_md.push_back({27'b0, m_cpsr[4:0]});
    old = m_cpsr;
    b   = mbank(old[4:0]);
    if (we) mwrite(int'(wr), wv);
    if (we && wr == 4'd15 && rs && b != 0) begin
      m_cpsr = m_spsr[b];
    end else if (cwe) begin
      nb = mbank(cwv[4:0]);
      if (nb != 0 && cwv[4:0] != old[4:0]) m_spsr[nb] = old;
      m_cpsr = cwv;
    end
  endtask

  task automatic idle();                                   step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr_reg(input logic [3:0] r, input logic [31:0] v); step(1, r, v, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic rd_reg(input logic [3:0] r);              step(0, 0, 0, 0, 1, r, 0, 0, 0, 0); endtask
  task automatic cpsr_wr(input logic [31:0] v);            step(0, 0, 0, 0, 0, 0, 0, 1, v, 0); endtask
  task automatic cpsr_rd();                                step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic mode_rd();                                step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask

  // Monitor: an output is due at the negedge after an edge that sampled its enable.
  bit f_rd, f_cp, f_md;
  always @(posedge clk) begin
    f_rd = read_en && rst_n;
    f_cp = cpsr_read_en && rst_n;
    f_md = mode_read_en && rst_n;
  end

  always @(negedge clk) begin
    if (f_rd) begin
      if (q_rd.size() == 0) check("read_value_unexpected", read_value, 32'hxxxx_xxxx);
      else check("read_value", read_value, q_rd.pop_front());
    end
    if (f_cp) begin
      if (q_cp.size() == 0) check("cpsr_read_unexpected", cpsr_read_value, 32'hxxxx_xxxx);
      else check("cpsr_read_value", cpsr_read_value, q_cp.pop_front());
    end
    if (f_md) begin
      if (q_md.size() == 0) check("mode_read_unexpected", mode_read_value, 32'hxxxx_xxxx);
      else check("mode_read_value", mode_read_value, q_md.pop_front());
    end
  end

  task automatic clear_inputs();
    write_en = 0; write_reg = 0; write_value = 0; write_restore_from_SPSR = 0;
    read_en = 0; read_reg = 0; cpsr_read_en = 0; cpsr_write_en = 0;
    cpsr_write_value = 0; mode_read_en = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [4:0] modes [0:8];

  initial begin
    modes = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F, 5'h1E, 5'h00};
    rst_n = 1'b0;
    clear_inputs();
    mreset();
    #1;
    check("reset_read_value", read_value, 32'h0);
    check("reset_cpsr_read_value", cpsr_read_value, 32'h0);
    check("reset_mode_read_value", mode_read_value, 32'h0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    cpsr_rd(); mode_rd();
    wr_reg(4, 32'hDEAD_BEEF); idle(); rd_reg(4);
    wr_reg(13, 32'h0000_1000); wr_reg(14, 32'h0000_2000); rd_reg(13); rd_reg(14);
    cpsr_wr(32'h0000_00D0); rd_reg(13);
    cpsr_wr(32'h0000_00D3); rd_reg(13);
    wr_reg(15, 32'h0000_3004); rd_reg(15); cpsr_rd();
    cpsr_wr(32'hCAFE_BABE); cpsr_rd(); mode_rd(); rd_reg(13);
    cpsr_wr(32'h0000_00D3); cpsr_wr(32'h0000_00D2);
    step(1, 15, 32'h0000_0100, 1, 0, 0, 0, 0, 0, 0);
    cpsr_rd(); rd_reg(15);
    // restore and CPSR write on the same edge, plus a same-edge read of the written register
    cpsr_wr(32'h0000_00D7);
    step(1, 15, 32'h0000_0200, 1, 1, 15, 1, 1, 32'h0000_00DB, 1);
    cpsr_rd(); mode_rd(); rd_reg(15);
    cpsr_wr(32'h0000_00D1); wr_reg(8, 32'h0000_0011); rd_reg(8);
    cpsr_wr(32'h0000_00D3); rd_reg(8); rd_reg(4);
    // restore in SYS mode leaves CPSR untouched
    cpsr_wr(32'h0000_00DF);
    step(1, 15, 32'h0000_0300, 1, 0, 0, 0, 0, 0, 0);
    cpsr_rd(); rd_reg(15);
    wr_reg(4, 32'h1234_5678); rd_reg(4);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check("midreset_read_value", read_value, 32'h0);
    check("midreset_cpsr_read_value", cpsr_read_value, 32'h0);
    check("midreset_mode_read_value", mode_read_value, 32'h0);
    mreset();
    q_rd.delete(); q_cp.delete(); q_md.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cpsr_rd(); rd_reg(4); rd_reg(13); mode_rd();

    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  wr, rr;
      logic [31:0] cwv;
      wr  = ($urandom_range(1, 0) == 1) ? 4'(8 + $urandom_range(7, 0)) : 4'($urandom_range(15, 0));
      rr  = ($urandom_range(1, 0) == 1) ? 4'(8 + $urandom_range(7, 0)) : 4'($urandom_range(15, 0));
      cwv = {$urandom() & 32'hFFFF_FFE0};
      cwv[4:0] = modes[$urandom_range(8, 0)];
      step($urandom_range(1, 0) == 1, wr, $urandom(), $urandom_range(1, 0) == 1,
           $urandom_range(1, 0) == 1, rr, $urandom_range(2, 0) == 0,
           $urandom_range(4, 0) == 0, cwv, $urandom_range(3, 0) == 0);
    end

    repeat (3) idle();
    @(negedge clk);
    #1;
    check("pending_expectations", 32'(q_rd.size() + q_cp.size() + q_md.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arm7_register_file.md
Name: arm7_register_file

Overview:
- Architectural register file for the ARM7 core. Holds R0–R15 with ARMv4 mode banking, the CPSR and the five SPSRs.
- Sits between decode/execute and writeback.
- One registered read port for general registers, one for CPSR, one for the current mode; one write port for general registers and one for CPSR.

Parameters:
- None; widths are architecturally fixed (32-bit data, 4-bit register index, 5-bit mode).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- write_en  in  1  write general register write_reg this edge
- write_reg  in  4  register index 0–15 (13=SP, 14=LR, 15=PC)
- write_value  in  32  data for write_reg
- write_restore_from_SPSR  in  1  with write_en and write_reg==15: also copy current-mode SPSR into CPSR
- read_en  in  1  sample register read_reg into read_value this edge
- read_reg  in  4  register index to read
- read_value  out  32  registered read data
- cpsr_read_en  in  1  sample CPSR into cpsr_read_value this edge
- cpsr_read_value  out  32  registered CPSR copy
- cpsr_write_en  in  1  write CPSR this edge
- cpsr_write_value  in  32  new CPSR value, all 32 bits stored verbatim
- mode_read_en  in  1  sample current mode into mode_read_value this edge
- mode_read_value  out  32  registered {27'b0, CPSR[4:0]}

Behaviour:
- Reset (rst_n low, async):
  - all R0–R15 and banked copies = 0; all SPSRs = 0
  - CPSR = 32'h0000_00D3 (SVC, I=1, F=1)
  - read_value, cpsr_read_value, mode_read_value = 0
- Mode = CPSR[4:0]; decoding (any other encoding, including 5'b11110, uses the USR bank and has no SPSR):
  - USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111
- Banking:
  - R0–R7 and R15 are shared by all modes.
  - R8–R12: FIQ has a private copy; all other modes share one copy.
  - R13–R14: private copies for FIQ, IRQ, SVC, ABT, UND; USR and SYS share one copy.
  - SPSR exists for FIQ, IRQ, SVC, ABT and UND only.
- Bank selection for reads and writes always uses the CPSR value held before the edge.
- Register write: on posedge, if write_en, the selected physical register <= write_value. R15 is stored unmodified (no alignment, no +8).
- Restore:
  - If write_en && write_reg==15 && write_restore_from_SPSR and the current mode has an SPSR, CPSR <= that SPSR on the same edge the PC is written.
  - In USR, SYS or an invalid mode the CPSR is unchanged.
  - write_restore_from_SPSR is ignored for any other write_reg.
- CPSR write:
  - On posedge, if cpsr_write_en, CPSR <= cpsr_write_value, stored verbatim with no field masking.
  - If the new mode field is an exception mode different from the old mode, that new mode's SPSR <= old CPSR on the same edge (exception-entry save).
- Same-edge conflict: if a restore and cpsr_write_en occur on the same edge, the restore wins; cpsr_write_value and the SPSR save are discarded.
- Reads (1-cycle latency):
  - On posedge with read_en, read_value <= current contents of the selected register. The pre-edge value is returned, so a same-edge write to that register is not visible.
  - cpsr_read_value and mode_read_value behave the same way under their own enables.
  - Each output holds its value while its enable is low.
- Three read ports and two write ports are fully independent within a cycle.

Test Plan:
- Reset, then R4 write 0xDEADBEEF with write_en for one edge; idle one edge; read_en R4 for one edge; after the following edge read_value == 0xDEADBEEF.
- SVC mode: write R13 = 0x00001000 and R14 = 0x00002000, read both back -> 0x00001000 and 0x00002000. Then cpsr_write 0x000000D0 (USR); read R13 -> 0 (user bank); cpsr_write 0x000000D3; read R13 -> 0x00001000.
- Write R15 = 0x00003004 with restore=0; read R15 -> 0x00003004; CPSR read -> 0x000000D3 unchanged.
- cpsr_write 0xCAFEBABE; cpsr_read -> 0xCAFEBABE; mode_read -> 0x0000001E; read R13 returns the USR-bank value.
- From SVC (0xD3), cpsr_write 0x000000D2 (IRQ); SPSR_irq = 0xD3. Write R15 = 0x100 with restore=1; CPSR read -> 0x000000D3 and R15 read -> 0x100.
- FIQ banking: in FIQ (0xD1) write R8 = 0x11; switch to SVC; read R8 -> 0. Assert rst_n low mid-sequence -> all outputs 0 immediately and CPSR read after release = 0xD3.
